// File: rtl/track_set_gearbox.sv
// Track-set gearbox: accepts N_IN packed track words per handshake and replays them as
// N_IN/N_OUT beats of N_OUT unpacked lanes with event framing. Optional macro: TW_PT_CLAMP_EN.
module track_set_gearbox #(
    parameter int TRACK_WORD_WIDTH = 96,
    parameter int PT_WIDTH         = 15,
    parameter int PHI_WIDTH        = 12,
    parameter int ETA_WIDTH        = 16,
    parameter int Z0_WIDTH         = 12,
    parameter int N_IN             = 18,
    parameter int N_OUT            = 6,
    parameter int SETS_IN_EVENT    = 95,
    parameter int PT_MAX_WIDTH     = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_IN*TRACK_WORD_WIDTH-1:0]     s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic                                 s_last,
    output logic [N_OUT*PT_WIDTH-1:0]            m_pt,
    output logic [N_OUT*PHI_WIDTH-1:0]           m_phi,
    output logic [N_OUT*ETA_WIDTH-1:0]           m_eta,
    output logic [N_OUT*Z0_WIDTH-1:0]            m_z0,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_set_last,
    output logic                                 m_event_last,
    output logic [$clog2(SETS_IN_EVENT)-1:0]     m_set_idx,
    output logic                                 err_framing
);

    localparam int R          = N_IN / N_OUT;
    localparam int B_W        = (R > 1) ? $clog2(R) : 1;
    localparam int CNT_W      = $clog2(SETS_IN_EVENT);
    localparam int TW         = TRACK_WORD_WIDTH;
    localparam int BEAT_BITS  = N_OUT * TW;
    localparam int FIELD_BITS = PT_WIDTH + PHI_WIDTH + ETA_WIDTH + Z0_WIDTH;
    localparam logic [B_W-1:0]   B_LAST  = B_W'(R - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETS_IN_EVENT - 1);

    if (N_IN % N_OUT != 0) begin : g_bad_ratio
        $error("track_set_gearbox: N_IN must be a multiple of N_OUT");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [B_W-1:0]        b_q, b_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_q;
    logic                  load;
    logic                  set_done;
    logic [N_IN*TW-1:0]    data_q;
    logic [BEAT_BITS-1:0]  beat_words;

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                    b_d     = '0;
                end
            end
            SHIFT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (b_q != B_LAST) begin
                        b_d = b_q + 1'b1;
                    end else begin
                        // Final beat consumed: a waiting set is loaded in the same cycle.
                        s_ready = 1'b1;
                        if (s_valid) begin
                            load = 1'b1;
                            b_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
            load    = 1'b0;
        end
    end

    assign set_done = m_valid && m_ready && (b_q == B_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (set_done) cnt_d = (last_q || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            b_q         <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            err_framing <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            // cnt_d is already the index the newly loaded set will carry.
            err_framing <= load && (s_last ^ (cnt_d == CNT_MAX));
            if (load) last_q <= s_last;
        end
    end

    // NOTE: the wide set register has no reset; outputs are masked by m_valid, so stale data never leaks.
    always_ff @(posedge clk) begin
        if (load) data_q <= s_data;
    end

    always_comb begin
        beat_words = '0;
        for (int bb = 0; bb < R; bb++) begin
            if (b_q == B_W'(bb)) beat_words = data_q[bb*BEAT_BITS +: BEAT_BITS];
        end
    end

    if (FIELD_BITS < TW) begin : g_unused
        logic [N_OUT-1:0] unused_hi;
        for (genvar j = 0; j < N_OUT; j++) begin : g_lane
            assign unused_hi[j] = ^beat_words[j*TW+FIELD_BITS +: TW-FIELD_BITS];
        end
    end

`ifdef TW_PT_CLAMP_EN
    localparam logic [PT_WIDTH-2:0] PT_MAG_MAX = (PT_WIDTH-1)'((1 << PT_MAX_WIDTH) - 1);

    function automatic logic [PT_WIDTH-1:0] shape_pt(input logic [PT_WIDTH-1:0] pt);
        // Charge bit passes through; only the magnitude saturates.
        if (pt[PT_WIDTH-2:0] > PT_MAG_MAX) return {pt[PT_WIDTH-1], PT_MAG_MAX};
        return pt;
    endfunction
`else
    localparam int unused_pt_max = PT_MAX_WIDTH;

    function automatic logic [PT_WIDTH-1:0] shape_pt(input logic [PT_WIDTH-1:0] pt);
        return pt;
    endfunction
`endif

    always_comb begin
        m_pt  = '0;
        m_phi = '0;
        m_eta = '0;
        m_z0  = '0;
        if (m_valid) begin
            for (int j = 0; j < N_OUT; j++) begin
                m_pt[j*PT_WIDTH +: PT_WIDTH]    = shape_pt(beat_words[j*TW +: PT_WIDTH]);
                m_phi[j*PHI_WIDTH +: PHI_WIDTH] = beat_words[j*TW+PT_WIDTH +: PHI_WIDTH];
                m_eta[j*ETA_WIDTH +: ETA_WIDTH] = beat_words[j*TW+PT_WIDTH+PHI_WIDTH +: ETA_WIDTH];
                m_z0[j*Z0_WIDTH +: Z0_WIDTH]    = beat_words[j*TW+PT_WIDTH+PHI_WIDTH+ETA_WIDTH +: Z0_WIDTH];
            end
        end
    end

    assign m_set_last   = m_valid && (b_q == B_LAST);
    assign m_event_last = m_valid && (last_q || cnt_q == CNT_MAX);
    assign m_set_idx    = m_valid ? cnt_q : '0;

endmodule
